vga_sync_gen: RTL and testbench

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

---
 rtl/vga_sync_gen.sv | 137 +++++++++++++
 tb/tb_vga_sync_gen.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA sync generator: walks an H_TOTAL x V_TOTAL raster and decodes the
// sync, blanking and frame-start signals for the current position.
// Latency: a pixel-rate rise captured on clk edge N is visible on the outputs right after edge N.
// Backpressure: none; the raster advances only on pix_clk_in rising edges and holds otherwise.
//
// Ports:
//   clk          system clock, the only clock in the block
//   reset_n      asynchronous active-low reset
//   pix_clk_in   divided pixel-rate square wave, sampled as data on clk
//   hsync/vsync  sync pulses, active level set by SYNC_POL
//   video_on     high while the position is inside the visible area
//   x/y          current horizontal/vertical position, zero-extended to 10 bits
//   frame_start  one-clk pulse on entry to position (0,0)
module vga_sync_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pix_clk_in,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  // Decode boundaries kept 32 bits wide: the sync end can equal the total,
  // which does not fit in the counter width when the back porch is zero.
  localparam logic [31:0] H_ACT_END  = 32'(H_ACTIVE);
  localparam logic [31:0] H_SYNC_BEG = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] H_SYNC_END = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] V_ACT_END  = 32'(V_ACTIVE);
  localparam logic [31:0] V_SYNC_BEG = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] V_SYNC_END = 32'(V_ACTIVE + V_FP + V_SYNC);

  logic          pix_d_q;
  logic          tick;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [31:0]   h_ext, v_ext;

  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          video_on_q, video_on_d;
  logic [9:0]    x_q, x_d;
  logic [9:0]    y_q, y_d;
  logic          frame_start_q, frame_start_d;

  // Rising-edge strobe of the pixel-rate wave; one clk wide.
  assign tick = pix_clk_in & ~pix_d_q;

  // Next-state raster position. The >= compares keep the counters inside
  // their range even if they were ever disturbed out of it.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (tick) begin
      if (h_cnt_q >= H_LAST) begin
        h_cnt_d = '0;
        if (v_cnt_q >= V_LAST) begin
          v_cnt_d = '0;
        end else begin
          v_cnt_d = v_cnt_q + VW'(1);
        end
      end else begin
        h_cnt_d = h_cnt_q + HW'(1);
      end
    end
  end

  assign h_ext = 32'(h_cnt_d);
  assign v_ext = 32'(v_cnt_d);

  // Outputs decode the next-state position so every registered output
  // describes the same pixel in the same cycle. Without a tick the
  // next-state equals the current state, so the outputs simply hold.
  always_comb begin
    x_d        = 10'(h_cnt_d);
    y_d        = 10'(v_cnt_d);
    video_on_d = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
    hsync_d    = ((h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_d    = ((v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    // Only the tick that lands on (0,0) raises it; cleared on all other cycles.
    frame_start_d = tick && (h_cnt_d == '0) && (v_cnt_d == '0);
  end

  // Reset parks the raster on the last pixel of the frame so the first
  // tick after release enters (0,0) and produces a frame_start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_d_q       <= 1'b0;
      h_cnt_q       <= H_LAST;
      v_cnt_q       <= V_LAST;
      x_q           <= 10'(H_TOTAL - 1);
      y_q           <= 10'(V_TOTAL - 1);
      video_on_q    <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      frame_start_q <= 1'b0;
    end else begin
      pix_d_q       <= pix_clk_in;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      x_q           <= x_d;
      y_q           <= y_d;
      video_on_q    <= video_on_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: a default-timing instance (active-low syncs)
// and a tiny-raster instance (15x8, active-high syncs) driven by the same inputs.
module tb_vga_sync_gen;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       pix = 1'b0;

  logic       hs0, vs0, vo0, fs0;
  logic [9:0] x0, y0;
  logic       hs1, vs1, vo1, fs1;
  logic [9:0] x1, y1;

  int checks = 0;
  int errors = 0;

  // Expected raster positions, advanced by the bench on every pixel rise.
  int h0 = 799, v0 = 524;
  int h1 = 14,  v1 = 7;
  bit efs0 = 1'b0, efs1 = 1'b0;
  int cyc = 0;

  always #5 clk = ~clk;

  vga_sync_gen dut0 (
    .clk(clk), .reset_n(reset_n), .pix_clk_in(pix),
    .hsync(hs0), .vsync(vs0), .video_on(vo0),
    .x(x0), .y(y0), .frame_start(fs0)
  );

  // Small raster: H 8+2+3+2 = 15, V 4+1+2+1 = 8, sync active-high.
  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b1)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .pix_clk_in(pix),
    .hsync(hs1), .vsync(vs1), .video_on(vo1),
    .x(x1), .y(y1), .frame_start(fs1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_all();
    // Default raster: hsync low for x 656..751, vsync low for y 490..491.
    chk("x0",  32'(x0),  32'(h0));
    chk("y0",  32'(y0),  32'(v0));
    chk("vo0", 32'(vo0), 32'(h0 < 640 && v0 < 480));
    chk("hs0", 32'(hs0), 32'(!(h0 >= 656 && h0 < 752)));
    chk("vs0", 32'(vs0), 32'(!(v0 >= 490 && v0 < 492)));
    chk("fs0", 32'(fs0), 32'(efs0));
    // Small raster: hsync high for x 10..12, vsync high for y 5..6.
    chk("x1",  32'(x1),  32'(h1));
    chk("y1",  32'(y1),  32'(v1));
    chk("vo1", 32'(vo1), 32'(h1 < 8 && v1 < 4));
    chk("hs1", 32'(hs1), 32'(h1 >= 10 && h1 < 13));
    chk("vs1", 32'(vs1), 32'(v1 >= 5 && v1 < 7));
    chk("fs1", 32'(fs1), 32'(efs1));
  endtask

  task automatic advance();
    h0 = (h0 == 799) ? 0 : h0 + 1;
    if (h0 == 0) v0 = (v0 == 524) ? 0 : v0 + 1;
    efs0 = (h0 == 0 && v0 == 0);
    h1 = (h1 == 14) ? 0 : h1 + 1;
    if (h1 == 0) v1 = (v1 == 7) ? 0 : v1 + 1;
    efs1 = (h1 == 0 && v1 == 0);
  endtask

  task automatic model_reset();
    h0 = 799; v0 = 524; h1 = 14; v1 = 7;
    efs0 = 1'b0; efs1 = 1'b0;
  endtask

  // Called at a negedge: optionally toggle the pixel wave, let one posedge
  // pass, then compare everything at the following negedge.
  task automatic step(input bit toggle);
    bit rise;
    rise = toggle && !pix;
    if (toggle) pix = ~pix;
    @(negedge clk);
    cyc++;
    if (rise) advance();
    else begin
      efs0 = 1'b0;
      efs1 = 1'b0;
    end
    check_all();
  endtask

  initial begin
    int hs_cnt, first_hs, vo_fall, vs1_cnt, vs1_first_y, nfs1, last_fs, guard;
    bit prev_vo;

    // Asynchronous reset, checked before any clock edge has occurred.
    #2 reset_n = 1'b0;
    #1;
    check_all();
    chk("rst_x0",  32'(x0),  32'd799);
    chk("rst_y0",  32'(y0),  32'd524);
    chk("rst_hs0", 32'(hs0), 32'd1);
    chk("rst_vs1", 32'(vs1), 32'd0);
    repeat (3) @(negedge clk);
    check_all();

    // Release; with pix constant nothing moves.
    reset_n = 1'b1;
    repeat (3) step(1'b0);

    // First rise enters (0,0) with frame_start.
    step(1'b1);
    chk("first_x0",  32'(x0),  32'd0);
    chk("first_y0",  32'(y0),  32'd0);
    chk("first_vo0", 32'(vo0), 32'd1);
    chk("first_fs0", 32'(fs0), 32'd1);
    chk("first_fs1", 32'(fs1), 32'd1);
    last_fs = cyc;
    step(1'b1);
    chk("fs0_one_clk", 32'(fs0), 32'd0);

    // Rest of line 0 on the default raster; the small raster runs several frames.
    hs_cnt = 0; first_hs = -1; vo_fall = -1; prev_vo = 1'b1;
    vs1_cnt = 0; vs1_first_y = -1; nfs1 = 0;
    for (int t = 1; t < 800; t++) begin
      step(1'b1);
      if (hs0 == 1'b0) begin
        hs_cnt++;
        if (first_hs < 0) first_hs = int'(x0);
      end
      if (prev_vo && !vo0 && vo_fall < 0) vo_fall = int'(x0);
      prev_vo = vo0;
      if (t < 120 && vs1) begin
        vs1_cnt++;
        if (vs1_first_y < 0) vs1_first_y = int'(y1);
      end
      if (fs1) begin
        nfs1++;
        chk("fs1_period_clk", 32'(cyc - last_fs), 32'd240);
        last_fs = cyc;
      end
      step(1'b1);
    end
    chk("hs0_start_x",   32'(first_hs), 32'd656);
    chk("hs0_width",     32'(hs_cnt),   32'd96);
    chk("vo0_fall_x",    32'(vo_fall),  32'd640);
    chk("vs1_width",     32'(vs1_cnt),  32'd30);
    chk("vs1_start_y",   32'(vs1_first_y), 32'd5);
    chk("fs1_count",     32'(nfs1),     32'd6);
    chk("line_end_x0",   32'(x0),       32'd799);

    // Line wrap: x 799 -> 0 with y incremented.
    step(1'b1);
    chk("wrap_x0", 32'(x0), 32'd0);
    chk("wrap_y0", 32'(y0), 32'd1);
    step(1'b1);

    // One rise, then pix held high for 100 clk: a single tick only.
    step(1'b1);
    chk("hold_x0", 32'(x0), 32'd1);
    repeat (100) step(1'b0);
    chk("hold_x0_after", 32'(x0), 32'd1);
    step(1'b1);

    // Move to x=300 and reset mid-line.
    guard = 0;
    while (h0 != 300 && guard < 2000) begin
      step(1'b1);
      step(1'b1);
      guard++;
    end
    chk("reach_x300", 32'(x0), 32'd300);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("mid_rst_x0",  32'(x0),  32'd799);
    chk("mid_rst_y0",  32'(y0),  32'd524);
    chk("mid_rst_vo0", 32'(vo0), 32'd0);
    repeat (2) @(negedge clk);
    check_all();
    reset_n = 1'b1;
    step(1'b0);
    step(1'b1);
    chk("post_rst_x0",  32'(x0),  32'd0);
    chk("post_rst_y0",  32'(y0),  32'd0);
    chk("post_rst_fs0", 32'(fs0), 32'd1);
    step(1'b1);
    chk("post_rst_fs0_clr", 32'(fs0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
